key_debounce: RTL and testbench

//  Per-key synchroniser and debouncer for the board's active-low push buttons.

---
 rtl/key_debounce.sv | 108 ++++++++++
 tb/tb_key_debounce.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Per-key 2-FF synchroniser and debouncer with registered press/release strobes.
// Optional hold detector for key_long, enabled by defining KEY_LONG_PRESS_EN.

module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_raw,
  output logic key_stable,
  output logic key_press,
  output logic key_release,
  output logic key_long
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 2) begin : g_chk_long
    $error("key_debounce: LONG_CYCLES must be >= 2");
  end

  // sync_pipe[1] is the only synchronised copy the debouncer looks at
  logic [1:0]    sync_pipe;
  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_pipe   <= 2'b11;
      cnt         <= '0;
      key_stable  <= 1'b1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync_pipe   <= {sync_pipe[0], key_raw};
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (sync_pipe[1] == key_stable) begin
        cnt <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + CW'(1);
      end else begin
        // strobes land in the same cycle the new level becomes visible
        key_stable  <= sync_pipe[1];
        cnt         <= '0;
        key_press   <= ~sync_pipe[1];
        key_release <= sync_pipe[1];
      end
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 2);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

  logic [HW-1:0] hold;

  // pulse is registered one count early so it coincides with hold == LONG_CYCLES-1;
  // saturation at LONG_CYCLES keeps it from firing again during the same hold
  always_ff @(posedge sys_clk) begin
    if (sys_rst || key_stable) begin
      hold     <= '0;
      key_long <= 1'b0;
    end else begin
      key_long <= (hold == HOLD_FIRE);
      if (hold != HOLD_SAT) hold <= hold + HW'(1);
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

module key_debounce #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_stable,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_lane (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_raw     (key_raw[i]),
      .key_stable  (key_stable[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
// key_long expectations follow KEY_LONG_PRESS_EN.

module tb_key_debounce;
  localparam int NK = 2;
  localparam int DC = 4;
  localparam int LC = 10;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [NK-1:0] key_raw = 2'b00;
  logic [NK-1:0] key_stable, key_press, key_release, key_long;
  logic [7:0]    obs;
  int            checks = 0;
  int            errors = 0;

  key_debounce #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DC),
    .LONG_CYCLES     (LC)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_raw     (key_raw),
    .key_stable  (key_stable),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  // {stable, press, release, long}
  assign obs = {key_stable, key_press, key_release, key_long};

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    sys_rst = 1'b1;
    key_raw = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 8'b11_00_00_00) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs, 8'b11_00_00_00);
      end
    end
    sys_rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp = (e < 6) ? 8'b11_00_00_00 : (e == 6) ? 8'b00_11_00_00 : 8'b00_00_00_00;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_release edge=%0d got=%b exp=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [5:0] exp;
    key_raw = 2'b11;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp = (e < 6) ? 6'b00_00_00 : 6'b11_00_11;
      checks++;
      if (obs[7:2] !== exp) begin
        errors++;
        $display("FAIL prep_release edge=%0d got=%b exp=%b", e, obs[7:2], exp);
      end
    end
    key_raw = 2'b10;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp = (e < 6) ? 6'b11_00_00 : (e == 6) ? 6'b10_01_00 : 6'b10_00_00;
      checks++;
      if (obs[7:2] !== exp) begin
        errors++;
        $display("FAIL clean_press edge=%0d got=%b exp=%b", e, obs[7:2], exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] exp;
    int         press1 = 0;
    for (int i = 0; i < 20; i++) begin
      key_raw[1] = ((i / 2) % 2 == 1);
      tick();
      if (key_press[1]) press1++;
      checks++;
      if (obs[7:2] !== 6'b10_00_00) begin
        errors++;
        $display("FAIL bounce cyc=%0d got=%b exp=%b", i, obs[7:2], 6'b10_00_00);
      end
    end
    key_raw[1] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (key_press[1]) press1++;
      exp = (e < 6) ? 6'b10_00_00 : (e == 6) ? 6'b00_10_00 : 6'b00_00_00;
      checks++;
      if (obs[7:2] !== exp) begin
        errors++;
        $display("FAIL bounce_settle edge=%0d got=%b exp=%b", e, obs[7:2], exp);
      end
    end
    checks++;
    if (press1 !== 1) begin
      errors++;
      $display("FAIL bounce_press_count got=%0d exp=1", press1);
    end
  endtask

  task automatic test_release();
    logic [5:0] exp;
    key_raw = 2'b11;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp = (e < 6) ? 6'b00_00_00 : (e == 6) ? 6'b11_00_11 : 6'b11_00_00;
      checks++;
      if (obs[7:2] !== exp) begin
        errors++;
        $display("FAIL release edge=%0d got=%b exp=%b", e, obs[7:2], exp);
      end
    end
  endtask

  task automatic test_long_press();
    logic [7:0] exp;
    logic [1:0] lexp;
    key_raw = 2'b10;
    for (int t = 1; t <= 30; t++) begin
      tick();
      lexp = (LONG_ON && t == 15) ? 2'b01 : 2'b00;
      exp  = (t < 6) ? 8'b11_00_00_00 : (t == 6) ? 8'b10_01_00_00 : {6'b10_00_00, lexp};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL long_hold t=%0d got=%b exp=%b", t, obs, exp);
      end
    end
    key_raw = 2'b11;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp = (t < 6) ? 8'b10_00_00_00 : (t == 6) ? 8'b11_00_01_00 : 8'b11_00_00_00;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL long_release t=%0d got=%b exp=%b", t, obs, exp);
      end
    end
    // raw low for 5 cycles gives a 5-cycle debounced press, too short for key_long
    key_raw = 2'b10;
    for (int t = 1; t <= 16; t++) begin
      tick();
      exp = (t < 6)   ? 8'b11_00_00_00 :
            (t == 6)  ? 8'b10_01_00_00 :
            (t < 11)  ? 8'b10_00_00_00 :
            (t == 11) ? 8'b11_00_01_00 : 8'b11_00_00_00;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL short_press t=%0d got=%b exp=%b", t, obs, exp);
      end
      if (t == 5) key_raw = 2'b11;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    key_raw = 2'b10;
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++;
      if (obs !== 8'b11_00_00_00) begin
        errors++;
        $display("FAIL mid_pre t=%0d got=%b exp=%b", t, obs, 8'b11_00_00_00);
      end
    end
    sys_rst = 1'b1;
    for (int t = 1; t <= 2; t++) begin
      tick();
      checks++;
      if (obs !== 8'b11_00_00_00) begin
        errors++;
        $display("FAIL mid_reset t=%0d got=%b exp=%b", t, obs, 8'b11_00_00_00);
      end
    end
    sys_rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp = (e < 6) ? 8'b11_00_00_00 : (e == 6) ? 8'b10_01_00_00 : 8'b10_00_00_00;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mid_restart edge=%0d got=%b exp=%b", e, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_long_press();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
